mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single chip-8 memory port (12-bit address, 8-bit data, read request/ack plus single-cycle write) between three requesters: CPU core, screen scan-out, and ROM/font loader. Sits between the requesters and mem; each requester sees the same read/ack/write protocol it would see talking to mem directly. Arbitration is fixed-priority with a starvation guard for scan-out, so display refresh cannot be locked out by a tight CPU loop.

Parameters:
ADDR_W, 12, memory address width
DATA_W, 8, memory data width
STARVE_LIMIT, 16, consecutive lost IDLE-cycle arbitrations before scan-out is promoted to top priority
CNT_W, 5, width of the starvation counter (must hold STARVE_LIMIT)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
Per requester X in {cpu, scr, ldr}, ports as follows:
X_read  in  1  read request, held until X_read_ack
X_read_idx  in  ADDR_W  read address
X_read_byte  out  DATA_W  read data, valid when X_read_ack=1
X_read_ack  out  1  one-cycle read completion pulse
X_write  in  1  write request, held until X_write_ack
X_write_idx  in  ADDR_W  write address
X_write_byte  in  DATA_W  write data
X_write_ack  out  1  one-cycle write completion pulse
Memory side:
mem_read  out  1  read request to mem
mem_read_idx  out  ADDR_W  read address to mem
mem_read_byte  in  DATA_W  read data from mem
mem_read_ack  in  1  read completion from mem
mem_write  out  1  write strobe to mem
mem_write_idx  out  ADDR_W  write address
mem_write_byte  out  DATA_W  write data

Behaviour:
- Reset: one clock (clk), asynchronous active-low reset (rst_n). On reset: state=IDLE, owner=none, starve_cnt=0, all X_read_ack/X_write_ack=0, X_read_byte=0. Memory-side outputs are combinational from state and are 0 in IDLE with no requests.
- States: IDLE, READ_WAIT.
- IDLE: the winner is selected combinationally from the current requests. Its request is forwarded to mem in the same cycle, with no added latency.
  - Default priority: ldr > cpu > scr.
  - If starve_cnt >= STARVE_LIMIT and scr_read=1, scr wins over all others.
- Write grant: the mem_write/idx/byte of the winner are driven for exactly one cycle. X_write_ack is registered and pulses the next cycle. State stays IDLE.
- Read grant: mem_read/idx of the winner are driven and owner is latched. IDLE -> READ_WAIT.
- READ_WAIT:
  - mem_read=1 and mem_read_idx=latched address while mem_read_ack=0.
  - When mem_read_ack=1: mem_read=0, owner's X_read_ack=1 and X_read_byte=mem_read_byte (combinational pass-through, same cycle). Go to IDLE next cycle.
  - Non-owners never see ack.
- Requester rule: deassert the request in the cycle its ack is high. A request still high in the following IDLE cycle is treated as a new request.
- One requester asserting read and write together: the write is served first, the read on a later grant.
- Starvation counter:
  - Increments (saturating at 2^CNT_W-1) on each IDLE cycle where scr_read=1 and scr does not win.
  - Clears when scr is granted, and when scr_read=0.
- Stray mem_read_ack in IDLE (for example a read in flight when reset was asserted) is ignored. No X_read_ack is generated for it.
- Reset asserted mid-READ_WAIT: return to IDLE immediately. The pending requester must reissue its read.
- Latency:
  - Uncontended read: ack arrives with mem's own latency; the arbiter adds 0 cycles in and 0 cycles out, plus 1 IDLE cycle between back-to-back grants.
  - Uncontended write: ack 1 cycle after request.

Decomposition:
- Shared package chip8_mem_pkg holds:
  - the requester id encoding (REQ_NONE, REQ_CPU, REQ_SCR, REQ_LDR)
  - the state encoding (ST_IDLE, ST_READ_WAIT)
  - ADDR_W/DATA_W defaults
- One natural sub-module, mem_arb_prio: a combinational priority picker. Inputs are the three request vectors and starve_hit; outputs are the winner id and the is_write flag.
- The FSM, counter and mux stay in mem_arbiter.

Test Plan:
- CPU read 0x200 alone, mem returns 0x12 after 1 cycle -> cpu_read_ack pulses once with cpu_read_byte=0x12; scr/ldr acks stay 0; mem_read drops in the ack cycle.
- cpu_read(0x020) and scr_read(0x140) asserted together -> cpu granted first; scr granted in the IDLE cycle after cpu's ack; each gets its own data.
- ldr_write(0x030,0xF0) alongside cpu_write(0x021,0x05) -> mem_write at 0x030 first, then 0x021 the next IDLE cycle; ldr_write_ack precedes cpu_write_ack by 1 cycle.
- CPU issues back-to-back reads continuously while scr_read is held -> scr granted once starve_cnt reaches 16; starve_cnt reads 0 after the grant.
- rst_n pulled low in READ_WAIT, mem_read_ack arrives 1 cycle after release -> no X_read_ack on any port; state IDLE; CPU reissue completes normally.
- cpu_read and cpu_write asserted together, write to 0x022 -> write serviced first (cpu_write_ack), then the read is granted and acked.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the chip-8 memory arbiter: requester ids, FSM states
// and default bus widths.
package chip8_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int NUM_REQ    = 3;

    // Array position of a requester is (id - 1).
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_CPU  = 2'd1,
        REQ_SCR  = 2'd2,
        REQ_LDR  = 2'd3
    } req_id_e;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_READ_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Read request/ack plus single-cycle write memory protocol. The same bundle is
// used between each requester and the arbiter and between the arbiter and mem.
interface mem_arbiter_if #(
    parameter int ADDR_W = chip8_mem_pkg::ADDR_W_DEF,
    parameter int DATA_W = chip8_mem_pkg::DATA_W_DEF
) ();
    logic              read;
    logic [ADDR_W-1:0] read_idx;
    logic [DATA_W-1:0] read_byte;
    logic              read_ack;
    logic              write;
    logic [ADDR_W-1:0] write_idx;
    logic [DATA_W-1:0] write_byte;
    logic              write_ack;

    modport master (
        output read, read_idx, write, write_idx, write_byte,
        input  read_byte, read_ack, write_ack
    );

    modport slave (
        input  read, read_idx, write, write_idx, write_byte,
        output read_byte, read_ack, write_ack
    );
endinterface

// File: rtl/mem_arb_prio.sv
// Combinational winner selection: ldr > cpu > scr, with scr promoted to the
// top when its read has been starved. A write beats a read of the same requester.
module mem_arb_prio
    import chip8_mem_pkg::*;
(
    input  logic [1:0] cpu_req,     // {write, read}
    input  logic [1:0] scr_req,
    input  logic [1:0] ldr_req,
    input  logic       starve_hit,
    output req_id_e    winner,
    output logic       is_write
);

    always_comb begin
        winner   = REQ_NONE;
        is_write = 1'b0;
        if (starve_hit && scr_req[0]) begin
            winner   = REQ_SCR;
            is_write = scr_req[1];
        end else if (|ldr_req) begin
            winner   = REQ_LDR;
            is_write = ldr_req[1];
        end else if (|cpu_req) begin
            winner   = REQ_CPU;
            is_write = cpu_req[1];
        end else if (|scr_req) begin
            winner   = REQ_SCR;
            is_write = scr_req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one chip-8 memory port between cpu, scan-out and loader. Requests are
// forwarded to mem in the cycle they win; read data passes straight back.
module mem_arbiter
    import chip8_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  cpu,
    mem_arbiter_if.slave  scr,
    mem_arbiter_if.slave  ldr,
    mem_arbiter_if.master mem
);

    state_e              state_reg, state_next;
    req_id_e             owner_reg, owner_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [CNT_W-1:0]    starve_cnt_reg, starve_cnt_next;
    logic [NUM_REQ-1:0]  wr_ack_reg, wr_ack_next;

    logic [NUM_REQ-1:0]  rd_req, wr_req_raw, wr_req, rd_ack, win_onehot;
    logic [ADDR_W-1:0]   rd_idx  [NUM_REQ];
    logic [ADDR_W-1:0]   wr_idx  [NUM_REQ];
    logic [DATA_W-1:0]   wr_byte [NUM_REQ];
    logic [DATA_W-1:0]   rd_byte [NUM_REQ];
    logic [ADDR_W-1:0]   sel_rd_idx, sel_wr_idx;
    logic [DATA_W-1:0]   sel_wr_byte;
    req_id_e             winner;
    logic                is_write;
    logic                starve_hit;
    logic                rd_done;

    assign rd_req     = {ldr.read,  scr.read,  cpu.read};
    assign wr_req_raw = {ldr.write, scr.write, cpu.write};
    // A write is still asserted during its ack cycle; it must not win again there.
    assign wr_req     = wr_req_raw & ~wr_ack_reg;

    assign rd_idx[0]  = cpu.read_idx;
    assign rd_idx[1]  = scr.read_idx;
    assign rd_idx[2]  = ldr.read_idx;
    assign wr_idx[0]  = cpu.write_idx;
    assign wr_idx[1]  = scr.write_idx;
    assign wr_idx[2]  = ldr.write_idx;
    assign wr_byte[0] = cpu.write_byte;
    assign wr_byte[1] = scr.write_byte;
    assign wr_byte[2] = ldr.write_byte;

    assign starve_hit = (starve_cnt_reg >= CNT_W'(STARVE_LIMIT));

    mem_arb_prio u_prio (
        .cpu_req    ({wr_req[0], rd_req[0]}),
        .scr_req    ({wr_req[1], rd_req[1]}),
        .ldr_req    ({wr_req[2], rd_req[2]}),
        .starve_hit (starve_hit),
        .winner     (winner),
        .is_write   (is_write)
    );

    always_comb begin
        win_onehot  = '0;
        sel_rd_idx  = '0;
        sel_wr_idx  = '0;
        sel_wr_byte = '0;
        case (winner)
            REQ_CPU: begin
                win_onehot = 3'b001; sel_rd_idx = rd_idx[0];
                sel_wr_idx = wr_idx[0]; sel_wr_byte = wr_byte[0];
            end
            REQ_SCR: begin
                win_onehot = 3'b010; sel_rd_idx = rd_idx[1];
                sel_wr_idx = wr_idx[1]; sel_wr_byte = wr_byte[1];
            end
            REQ_LDR: begin
                win_onehot = 3'b100; sel_rd_idx = rd_idx[2];
                sel_wr_idx = wr_idx[2]; sel_wr_byte = wr_byte[2];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        addr_next      = addr_reg;
        wr_ack_next    = '0;
        mem.read       = 1'b0;
        mem.read_idx   = '0;
        mem.write      = 1'b0;
        mem.write_idx  = '0;
        mem.write_byte = '0;
        case (state_reg)
            ST_IDLE: begin
                if (winner != REQ_NONE) begin
                    if (is_write) begin
                        mem.write      = 1'b1;
                        mem.write_idx  = sel_wr_idx;
                        mem.write_byte = sel_wr_byte;
                        wr_ack_next    = win_onehot;
                    end else begin
                        mem.read     = 1'b1;
                        mem.read_idx = sel_rd_idx;
                        owner_next   = winner;
                        addr_next    = sel_rd_idx;
                        state_next   = ST_READ_WAIT;
                    end
                end
            end
            ST_READ_WAIT: begin
                if (mem.read_ack) begin
                    owner_next = REQ_NONE;
                    state_next = ST_IDLE;
                end else begin
                    mem.read     = 1'b1;
                    mem.read_idx = addr_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counts IDLE arbitrations lost by a pending scan-out read.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!scr.read) begin
            starve_cnt_next = '0;
        end else if (state_reg == ST_IDLE) begin
            if (winner == REQ_SCR)
                starve_cnt_next = '0;
            else if (starve_cnt_reg != '1)
                starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= REQ_NONE;
            addr_reg       <= '0;
            starve_cnt_reg <= '0;
            wr_ack_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            addr_reg       <= addr_next;
            starve_cnt_reg <= starve_cnt_next;
            wr_ack_reg     <= wr_ack_next;
        end
    end

    // Acks seen in IDLE are strays (e.g. from before reset) and are dropped here.
    assign rd_done = (state_reg == ST_READ_WAIT) && mem.read_ack;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rd_ret
        assign rd_ack[gi]  = rd_done && (owner_reg == req_id_e'(2'(gi + 1)));
        assign rd_byte[gi] = rd_ack[gi] ? mem.read_byte : '0;
    end

    assign cpu.read_ack  = rd_ack[0];
    assign scr.read_ack  = rd_ack[1];
    assign ldr.read_ack  = rd_ack[2];
    assign cpu.read_byte = rd_byte[0];
    assign scr.read_byte = rd_byte[1];
    assign ldr.read_byte = rd_byte[2];
    assign cpu.write_ack = wr_ack_reg[0];
    assign scr.write_ack = wr_ack_reg[1];
    assign ldr.write_ack = wr_ack_reg[2];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 ns after the rising edge and
// outputs are sampled 1 ns later, so every sample sees one settled cycle.
module tb_mem_arbiter;
    import chip8_mem_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mem_arbiter_if cpu_if ();
    mem_arbiter_if scr_if ();
    mem_arbiter_if ldr_if ();
    mem_arbiter_if mem_if ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cpu   (cpu_if),
        .scr   (scr_if),
        .ldr   (ldr_if),
        .mem   (mem_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_if.read = 0; cpu_if.read_idx = '0; cpu_if.write = 0; cpu_if.write_idx = '0; cpu_if.write_byte = '0;
        scr_if.read = 0; scr_if.read_idx = '0; scr_if.write = 0; scr_if.write_idx = '0; scr_if.write_byte = '0;
        ldr_if.read = 0; ldr_if.read_idx = '0; ldr_if.write = 0; ldr_if.write_idx = '0; ldr_if.write_byte = '0;
        mem_if.read_byte = '0; mem_if.read_ack = 0; mem_if.write_ack = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        step(); step();
        #1;
        n_vec++;
        if (dut.state_reg !== ST_IDLE || dut.owner_reg !== REQ_NONE || dut.starve_cnt_reg !== 5'd0) begin
            n_err++; $display("FAIL reset_state: state=%0d owner=%0d cnt=%0d, want 0/0/0", dut.state_reg, dut.owner_reg, dut.starve_cnt_reg);
        end
        n_vec++;
        if ({mem_if.read, mem_if.write, mem_if.read_idx, mem_if.write_idx, mem_if.write_byte} !== '0) begin
            n_err++; $display("FAIL reset_mem_side: rd=%b wr=%b ridx=%h widx=%h wb=%h, want all 0", mem_if.read, mem_if.write, mem_if.read_idx, mem_if.write_idx, mem_if.write_byte);
        end
        n_vec++;
        if ({cpu_if.read_ack, scr_if.read_ack, ldr_if.read_ack, cpu_if.write_ack, scr_if.write_ack, ldr_if.write_ack} !== 6'b0
            || {cpu_if.read_byte, scr_if.read_byte, ldr_if.read_byte} !== 24'h0) begin
            n_err++; $display("FAIL reset_acks: acks/bytes not zero");
        end
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_single_read();
        cpu_if.read = 1; cpu_if.read_idx = 12'h200;
        #1;
        n_vec++;
        if (mem_if.read !== 1'b1 || mem_if.read_idx !== 12'h200) begin
            n_err++; $display("FAIL single_issue: mem_read=%b idx=%h, want 1/200", mem_if.read, mem_if.read_idx);
        end
        step();
        mem_if.read_ack = 1; mem_if.read_byte = 8'h12;
        #1;
        n_vec++;
        if ({cpu_if.read_ack, scr_if.read_ack, ldr_if.read_ack} !== 3'b100 || cpu_if.read_byte !== 8'h12) begin
            n_err++; $display("FAIL single_ack: acks(c,s,l)=%b byte=%h, want 100/12", {cpu_if.read_ack, scr_if.read_ack, ldr_if.read_ack}, cpu_if.read_byte);
        end
        n_vec++;
        if (mem_if.read !== 1'b0) begin
            n_err++; $display("FAIL single_drop: mem_read=%b in ack cycle, want 0", mem_if.read);
        end
        step();
        cpu_if.read = 0; mem_if.read_ack = 0;
        #1;
        n_vec++;
        if (cpu_if.read_ack !== 1'b0 || dut.state_reg !== ST_IDLE || mem_if.read !== 1'b0) begin
            n_err++; $display("FAIL single_after: ack=%b state=%0d mem_read=%b, want 0/IDLE/0", cpu_if.read_ack, dut.state_reg, mem_if.read);
        end
    endtask

    task automatic test_contended_read();
        cpu_if.read = 1; cpu_if.read_idx = 12'h020;
        scr_if.read = 1; scr_if.read_idx = 12'h140;
        #1;
        n_vec++;
        if (mem_if.read !== 1'b1 || mem_if.read_idx !== 12'h020) begin
            n_err++; $display("FAIL contend_first: mem_read=%b idx=%h, want 1/020", mem_if.read, mem_if.read_idx);
        end
        step();
        mem_if.read_ack = 1; mem_if.read_byte = 8'h5A;
        #1;
        n_vec++;
        if ({cpu_if.read_ack, scr_if.read_ack} !== 2'b10 || cpu_if.read_byte !== 8'h5A || scr_if.read_byte !== 8'h00) begin
            n_err++; $display("FAIL contend_cpu_ack: acks(c,s)=%b cbyte=%h sbyte=%h, want 10/5A/00", {cpu_if.read_ack, scr_if.read_ack}, cpu_if.read_byte, scr_if.read_byte);
        end
        step();
        cpu_if.read = 0; mem_if.read_ack = 0;
        #1;
        n_vec++;
        if (mem_if.read !== 1'b1 || mem_if.read_idx !== 12'h140) begin
            n_err++; $display("FAIL contend_second: mem_read=%b idx=%h, want 1/140", mem_if.read, mem_if.read_idx);
        end
        step();
        mem_if.read_ack = 1; mem_if.read_byte = 8'hC3;
        #1;
        n_vec++;
        if ({cpu_if.read_ack, scr_if.read_ack} !== 2'b01 || scr_if.read_byte !== 8'hC3 || cpu_if.read_byte !== 8'h00) begin
            n_err++; $display("FAIL contend_scr_ack: acks(c,s)=%b sbyte=%h cbyte=%h, want 01/C3/00", {cpu_if.read_ack, scr_if.read_ack}, scr_if.read_byte, cpu_if.read_byte);
        end
        step();
        scr_if.read = 0; mem_if.read_ack = 0;
    endtask

    task automatic test_write_priority();
        ldr_if.write = 1; ldr_if.write_idx = 12'h030; ldr_if.write_byte = 8'hF0;
        cpu_if.write = 1; cpu_if.write_idx = 12'h021; cpu_if.write_byte = 8'h05;
        #1;
        n_vec++;
        if ({mem_if.write, mem_if.write_idx, mem_if.write_byte} !== {1'b1, 12'h030, 8'hF0} || mem_if.read !== 1'b0) begin
            n_err++; $display("FAIL write_first: wr=%b idx=%h byte=%h, want 1/030/F0", mem_if.write, mem_if.write_idx, mem_if.write_byte);
        end
        step();
        #1;
        n_vec++;
        if ({ldr_if.write_ack, cpu_if.write_ack} !== 2'b10 || {mem_if.write, mem_if.write_idx, mem_if.write_byte} !== {1'b1, 12'h021, 8'h05}) begin
            n_err++; $display("FAIL write_second: acks(l,c)=%b wr=%b idx=%h byte=%h, want 10/1/021/05", {ldr_if.write_ack, cpu_if.write_ack}, mem_if.write, mem_if.write_idx, mem_if.write_byte);
        end
        step();
        ldr_if.write = 0;
        #1;
        n_vec++;
        if ({ldr_if.write_ack, cpu_if.write_ack} !== 2'b01 || mem_if.write !== 1'b0) begin
            n_err++; $display("FAIL write_cpu_ack: acks(l,c)=%b mem_write=%b, want 01/0", {ldr_if.write_ack, cpu_if.write_ack}, mem_if.write);
        end
        step();
        cpu_if.write = 0;
        #1;
        n_vec++;
        if ({ldr_if.write_ack, cpu_if.write_ack, scr_if.write_ack} !== 3'b000) begin
            n_err++; $display("FAIL write_quiet: acks(l,c,s)=%b, want 000", {ldr_if.write_ack, cpu_if.write_ack, scr_if.write_ack});
        end
    endtask

    task automatic test_starvation();
        int  cpu_grants;
        bit  scr_won;
        cpu_grants = 0;
        scr_won    = 0;
        cpu_if.read = 1; cpu_if.read_idx = 12'h210;
        scr_if.read = 1; scr_if.read_idx = 12'h100;
        // Each loop pass is one IDLE grant cycle then one READ_WAIT ack cycle.
        for (int i = 0; i < 40 && !scr_won; i++) begin
            mem_if.read_ack = 0;
            #1;
            if (mem_if.read === 1'b1 && mem_if.read_idx === 12'h100) begin
                scr_won = 1;
                n_vec++;
                if (dut.starve_cnt_reg !== 5'd16) begin
                    n_err++; $display("FAIL starve_cnt_at_grant: cnt=%0d, want 16", dut.starve_cnt_reg);
                end
            end else if (mem_if.read === 1'b1 && mem_if.read_idx === 12'h210) begin
                cpu_grants++;
            end
            step();
            mem_if.read_ack = 1; mem_if.read_byte = 8'(i);
            #1;
            if (scr_won) begin
                n_vec++;
                if (scr_if.read_ack !== 1'b1 || cpu_if.read_ack !== 1'b0 || scr_if.read_byte !== 8'(i)) begin
                    n_err++; $display("FAIL starve_scr_ack: sack=%b cack=%b byte=%h, want 1/0/%h", scr_if.read_ack, cpu_if.read_ack, scr_if.read_byte, 8'(i));
                end
                n_vec++;
                if (dut.starve_cnt_reg !== 5'd0) begin
                    n_err++; $display("FAIL starve_cnt_clear: cnt=%0d, want 0", dut.starve_cnt_reg);
                end
            end
            step();
        end
        n_vec++;
        if (!scr_won || cpu_grants !== 16) begin
            n_err++; $display("FAIL starve_grant: scr_won=%0d cpu_grants=%0d, want 1/16", scr_won, cpu_grants);
        end
        cpu_if.read = 0; scr_if.read = 0; mem_if.read_ack = 0;
        step();
    endtask

    task automatic test_reset_mid_read();
        cpu_if.read = 1; cpu_if.read_idx = 12'h300;
        step();
        #1;
        n_vec++;
        if (dut.state_reg !== ST_READ_WAIT) begin
            n_err++; $display("FAIL rstmid_enter: state=%0d, want READ_WAIT", dut.state_reg);
        end
        cpu_if.read = 0;
        rst_n = 0;
        #1;
        n_vec++;
        if (dut.state_reg !== ST_IDLE || mem_if.read !== 1'b0) begin
            n_err++; $display("FAIL rstmid_async: state=%0d mem_read=%b, want IDLE/0", dut.state_reg, mem_if.read);
        end
        step();
        rst_n = 1;
        step();
        mem_if.read_ack = 1; mem_if.read_byte = 8'hEE;
        #1;
        n_vec++;
        if ({cpu_if.read_ack, scr_if.read_ack, ldr_if.read_ack} !== 3'b000 || cpu_if.read_byte !== 8'h00 || dut.state_reg !== ST_IDLE) begin
            n_err++; $display("FAIL rstmid_stray: acks=%b cbyte=%h state=%0d, want 000/00/IDLE", {cpu_if.read_ack, scr_if.read_ack, ldr_if.read_ack}, cpu_if.read_byte, dut.state_reg);
        end
        step();
        mem_if.read_ack = 0;
        cpu_if.read = 1;
        #1;
        n_vec++;
        if (mem_if.read !== 1'b1 || mem_if.read_idx !== 12'h300) begin
            n_err++; $display("FAIL rstmid_reissue: mem_read=%b idx=%h, want 1/300", mem_if.read, mem_if.read_idx);
        end
        step();
        mem_if.read_ack = 1; mem_if.read_byte = 8'h77;
        #1;
        n_vec++;
        if (cpu_if.read_ack !== 1'b1 || cpu_if.read_byte !== 8'h77) begin
            n_err++; $display("FAIL rstmid_done: ack=%b byte=%h, want 1/77", cpu_if.read_ack, cpu_if.read_byte);
        end
        step();
        cpu_if.read = 0; mem_if.read_ack = 0;
    endtask

    task automatic test_read_write_same();
        cpu_if.read  = 1; cpu_if.read_idx = 12'h024;
        cpu_if.write = 1; cpu_if.write_idx = 12'h022; cpu_if.write_byte = 8'hAB;
        #1;
        n_vec++;
        if ({mem_if.write, mem_if.write_idx, mem_if.write_byte} !== {1'b1, 12'h022, 8'hAB} || mem_if.read !== 1'b0) begin
            n_err++; $display("FAIL rw_write_first: wr=%b idx=%h byte=%h rd=%b, want 1/022/AB/0", mem_if.write, mem_if.write_idx, mem_if.write_byte, mem_if.read);
        end
        step();
        #1;
        n_vec++;
        if (cpu_if.write_ack !== 1'b1 || mem_if.write !== 1'b0 || mem_if.read !== 1'b1 || mem_if.read_idx !== 12'h024) begin
            n_err++; $display("FAIL rw_read_grant: wack=%b mwr=%b mrd=%b idx=%h, want 1/0/1/024", cpu_if.write_ack, mem_if.write, mem_if.read, mem_if.read_idx);
        end
        step();
        cpu_if.write = 0;
        mem_if.read_ack = 1; mem_if.read_byte = 8'h3C;
        #1;
        n_vec++;
        if (cpu_if.read_ack !== 1'b1 || cpu_if.read_byte !== 8'h3C || cpu_if.write_ack !== 1'b0) begin
            n_err++; $display("FAIL rw_read_ack: rack=%b byte=%h wack=%b, want 1/3C/0", cpu_if.read_ack, cpu_if.read_byte, cpu_if.write_ack);
        end
        step();
        cpu_if.read = 0; mem_if.read_ack = 0;
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 0;
        test_reset();
        test_single_read();
        test_contended_read();
        test_write_priority();
        test_starvation();
        test_reset_mid_read();
        test_read_write_same();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
